lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator: accepts one load or store per transaction from the execute stage and drives the data-memory port as bus master. Performs byte/half/word lane steering, write-strobe generation, load sign/zero extension and a response timeout. Sits between the core's execute/writeback path and the data memory, which acts as responder.

## Interface
Parameters:
- TIMEOUT, 16: WAIT-state cycles allowed for mem_rvalid before an error response (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, reserved size or timeout
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_addr  out  32  word address, {req_addr[31:2], 2'b00}
- mem_wen  out  1  write request
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes; 0 on reads
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch all req_* fields. Reserved size → RESP with err. Misaligned (see Configuration) → RESP with err. Otherwise → REQ.
- REQ: mem_valid=1; mem_addr/mem_wen/mem_wdata/mem_wstrb held stable from latched fields until mem_ready. On mem_valid&&mem_ready: store → RESP with err=0; load → WAIT with timeout counter cleared.
- WAIT: counter increments each cycle. On mem_rvalid: capture extracted data → RESP with err=0. If counter reaches TIMEOUT-1 without mem_rvalid → RESP with err=1, rdata=0. If mem_rvalid arrives on the timeout cycle, data wins and err=0.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- Store lanes: byte → wdata {4{b[7:0]}}, wstrb 4'b0001<<addr[1:0]; half → {2{h[15:0]}}, 4'b0011<<addr[1:0]; word → wdata unchanged, 4'b1111.
- Load extraction: mem_rdata >> (8*addr[1:0]), then truncate to size; extend per req_unsigned; word ignores req_unsigned.
- mem_rvalid outside WAIT is ignored. mem_ready outside REQ is ignored.
- req_ready=0 in REQ, WAIT and RESP; new requests are not accepted until back in IDLE.

## Timing
- While rst_n=0 at a clock edge: state→IDLE, counter→0, all outputs 0 including req_ready; req_ready=1 from the first cycle with rst_n=1.
- Reset mid-transaction aborts it: no resp_valid, mem_valid drops the cycle after the reset edge.
- Store, zero-wait memory: accept at cycle 0, mem_valid cycle 1, resp_valid cycle 2, req_ready cycle 3.
- Load, mem_rvalid one cycle after handshake: resp_valid cycle 3.
- Error detected in IDLE: resp_valid the following cycle, no mem_valid.
- Outputs are registered or pure decodes of registered state/latched fields; no input→output combinational path.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half with addr[0]≠0 or word with addr[1:0]≠0 → error response, no memory access.
- Undefined: misaligned accesses proceed with the offending low address bits forced to 0 (half: addr[0]=0; word: addr[1:0]=0); resp_err never set for misalignment.

## Test plan
- Store byte 0xA5 to 0x1003 → mem_addr 0x1000, mem_wdata 0xA5A5A5A5, mem_wstrb 4'b1000, resp_err 0.
- Load half signed at 0x2002, mem_rdata 0x80011234 → resp_rdata 0xFFFF8001; unsigned → 0x00008001.
- Load word, mem_ready low 5 cycles → mem_valid and fields held stable 5 cycles; rdata 0xDEADBEEF returned.
- Load with no mem_rvalid, TIMEOUT=16 → resp_valid, resp_err 1, rdata 0 exactly 16 cycles after entering WAIT; rvalid on that same cycle → err 0.
- Word load at 0x3001: with LSU_MISALIGN_TRAP_EN → err 1, no mem_valid; without → mem_addr 0x3000, err 0. Size 3 → err 1 in both builds.
- rst_n low during WAIT → next cycle IDLE, req_ready 1 after release, no resp_valid pulse.

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store initiator: lane steering, strobes, load extension and response timeout.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module lsu_mem_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    off_q;

    logic [1:0]    off_c;
    logic [3:0]    strb_c;
    logic [31:0]   wdata_c;
    logic          bad_c;
    logic [31:0]   shift_c;
    logic [31:0]   ext_c;

    // Request decode: effective lane offset (misaligned bits forced low), store lanes, error check.
    always_comb begin
        off_c   = req_addr[1:0];
        strb_c  = 4'b1111;
        wdata_c = req_wdata;
        case (req_size)
            2'd0: begin
                strb_c  = 4'b0001 << off_c;
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                off_c   = {req_addr[1], 1'b0};
                strb_c  = 4'b0011 << off_c;
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                off_c   = 2'b00;
                strb_c  = 4'b1111;
                wdata_c = req_wdata;
            end
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        bad_c = (req_size == 2'd3)
              || ((req_size == 2'd1) && req_addr[0])
              || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
        bad_c = (req_size == 2'd3);
`endif
    end

    // Load extraction from the addressed lane of the returned word.
    always_comb begin
        shift_c = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ext_c = uns_q ? {24'd0, shift_c[7:0]}  : {{24{shift_c[7]}}, shift_c[7:0]};
            2'd1:    ext_c = uns_q ? {16'd0, shift_c[15:0]} : {{16{shift_c[15]}}, shift_c[15:0]};
            default: ext_c = shift_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_ready && req_valid) begin
                        req_ready <= 1'b0;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        off_q     <= off_c;
                        if (bad_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= REQ;
                            mem_valid <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wen   <= req_wen;
                            mem_wdata <= req_wen ? wdata_c : 32'd0;
                            mem_wstrb <= req_wen ? strb_c : 4'd0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wen   <= 1'b0;
                        mem_wstrb <= '0;
                        if (mem_wen) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                WAIT: begin
                    // Data arriving on the final allowed cycle still wins over the timeout.
                    if (mem_rvalid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= ext_c;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: expected responses queued at stimulus, checked at resp_valid.
module tb_lsu_mem_master;

    localparam int TO = 16;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;

    lsu_mem_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor: every resp_valid pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("spurious_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("resp_missing", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // One transaction; rv_dly < 0 means the memory never returns read data.
    task automatic run(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] word, input int rdy_dly, input int rv_dly);
        int          off, a, w, n;
        logic        mis, idle_err, sel;
        logic [7:0]  by [4];
        logic [31:0] ea, ew, rd;
        logic [3:0]  es;
        exp_t        e;

        off = (size == 2'd0) ? int'(addr[1:0]) : (size == 2'd1) ? (addr[1] ? 2 : 0) : 0;
        mis = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
        idle_err = (size == 2'd3) || (TRAP && mis);

        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);

        @(posedge clk); #1;
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = 32'($urandom);
        req_wdata = 32'($urandom);
        a = cyc;

        if (idle_err) begin
            e.rdata = 32'd0; e.err = 1'b1; e.cyc = a;
            sb.push_back(e);
            @(negedge clk);
            check("no_mem_on_err", 32'(mem_valid), 32'd0);
        end else begin
            ea = {addr[31:2], 2'b00};
            for (int i = 0; i < 4; i++) begin
                sel = (size == 2'd2) || (i == off) || ((size == 2'd1) && (i == off + 1));
                es[i] = wen && sel;
                ew[8*i +: 8] = (size == 2'd2) ? wdata[8*i +: 8] :
                               (size == 2'd1) ? wdata[8*(i%2) +: 8] : wdata[7:0];
                by[i] = word[8*i +: 8];
            end
            for (int k = 0; k <= rdy_dly; k++) begin
                @(negedge clk);
                check("mem_valid", 32'(mem_valid), 32'd1);
                check("mem_addr", mem_addr, ea);
                check("mem_wen", 32'(mem_wen), 32'(wen));
                check("mem_wstrb", 32'(mem_wstrb), 32'(es));
                if (wen) check("mem_wdata", mem_wdata, ew);
                check("req_ready_busy", 32'(req_ready), 32'd0);
                mem_ready = (k == rdy_dly);
                @(posedge clk); #1;
                mem_ready = 1'b0;
            end
            if (wen) begin
                e.rdata = 32'd0; e.err = 1'b0; e.cyc = cyc;
                sb.push_back(e);
            end else begin
                w = cyc;
                if (rv_dly >= 0 && rv_dly < TO) begin
                    case (size)
                        2'd0:    rd = uns ? 32'(by[off]) : 32'($signed(by[off]));
                        2'd1:    rd = uns ? 32'({by[off+1], by[off]}) : 32'($signed({by[off+1], by[off]}));
                        default: rd = word;
                    endcase
                    e.rdata = rd; e.err = 1'b0; e.cyc = w + rv_dly + 1;
                    sb.push_back(e);
                    repeat (rv_dly) begin
                        @(posedge clk); #1;
                    end
                    mem_rvalid = 1'b1; mem_rdata = word;
                    @(posedge clk); #1;
                    mem_rvalid = 1'b0; mem_rdata = 32'($urandom);
                end else begin
                    e.rdata = 32'd0; e.err = 1'b1; e.cyc = w + TO;
                    sb.push_back(e);
                end
            end
        end
        drain();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_ready", 32'(req_ready), 32'd1);

        // Directed cases.
        run(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0);
        run(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
        run(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
        run(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 5, 2);
        run(1'b0, 2'd2, 1'b0, 32'h0000_4004, 32'h0, 32'h1111_2222, 0, -1);
        run(1'b0, 2'd2, 1'b0, 32'h0000_4008, 32'h0, 32'h1234_5678, 0, TO - 1);
        run(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 0, 0);
        run(1'b0, 2'd3, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
        run(1'b1, 2'd3, 1'b0, 32'h0000_3000, 32'h5555_5555, 32'h0, 0, 0);
        run(1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 1, 0);
        run(1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'h0102_0304, 32'h0, 0, 0);
        run(1'b0, 2'd0, 1'b0, 32'h0000_5001, 32'h0, 32'h0000_8000, 0, 1);
        run(1'b0, 2'd0, 1'b1, 32'h0000_5003, 32'h0, 32'hF000_0000, 0, 0);
        run(1'b0, 2'd1, 1'b0, 32'h0000_5003, 32'h0, 32'h9ABC_DEF0, 0, 0);

        // Reset while waiting for read data aborts silently.
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h0000_6000;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_mem_valid", 32'(mem_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_release_ready", 32'(req_ready), 32'd1);
        repeat (TO + 4) @(posedge clk);
        #1;

        // Short randomised tail.
        for (int i = 0; i < 8; i++) begin
            run(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom),
                32'($urandom), 32'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
